// File: rtl/spi_adc_multi.sv
// Multi-channel SPI reader for AD7476A-class ADCs sharing CS/SCK, with optional
// per-channel averaging and a single-cycle result strobe.
module spi_adc_multi #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned QUIET_CYC  = 4,
  parameter int unsigned AVG_LOG2   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic                     trigger_i,
  output logic                     spi_cs_no,
  output logic                     spi_sck_o,
  input  logic [N_CH-1:0]          spi_miso_i,
  output logic                     busy_o,
  output logic                     overrun_o,
  output logic                     data_update_o,
  output logic [N_CH*DATA_W-1:0]   data_o
);

  localparam int unsigned AW = DATA_W + AVG_LOG2;
  localparam int unsigned NW = AVG_LOG2 + 1;
  localparam int unsigned CW = $clog2(CLK_DIV + QUIET_CYC + 1);
  localparam int unsigned TW = $clog2(SAMPLE_DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TAIL  = 3'd3;
  localparam logic [2:0] S_QUIET = 3'd4;

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYC - 1);
  localparam logic [TW-1:0] TMR_LAST   = TW'(SAMPLE_DIV - 1);
  localparam logic [NW-1:0] AVG_LAST   = NW'((1 << AVG_LOG2) - 1);

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic                   cs_q, cs_d, sck_q, sck_d, busy_q, busy_d;
  logic                   ovr_q, ovr_d, upd_q, upd_d, mode_q, mode_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [N_CH*16-1:0]     shift_q, shift_d;
  logic [N_CH*AW-1:0]     acc_q, acc_d;
  logic [NW-1:0]          avg_q, avg_d;
  logic [N_CH*DATA_W-1:0] data_q, data_d;
  logic [N_CH*AW-1:0]     sum_c;
  logic                   mode_eff_c, tick_c, req_c;

  // Mode is sampled live only while idle so a frame in flight keeps its source.
  assign mode_eff_c = (state_q == S_IDLE) ? mode_i : mode_q;
  assign tick_c     = en_i & ~mode_eff_c & (timer_q == TMR_LAST);
  assign req_c      = en_i & (mode_eff_c ? trigger_i : tick_c);

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum_c[k*AW +: AW] = acc_q[k*AW +: AW] + AW'(shift_q[k*16 +: DATA_W]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    ovr_d   = 1'b0;
    upd_d   = 1'b0;
    mode_d  = mode_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    avg_d   = avg_q;
    data_d  = data_q;
    timer_d = '0;

    if (en_i && !mode_eff_c) begin
      timer_d = tick_c ? '0 : timer_q + TW'(1);
    end

    if (req_c && state_q != S_IDLE) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        mode_d = mode_i;
        if (!en_i) begin
          acc_d = '0;
          avg_d = '0;
        end
        if (req_c) begin
          state_d = S_LEAD;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_LEAD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            for (int k = 0; k < N_CH; k++) begin
              shift_d[k*16 +: 16] = (shift_q[k*16 +: 16] << 1) | 16'(spi_miso_i[k]);
            end
          end else if (bit_q == 4'd15) begin
            state_d = S_TAIL;
          end else begin
            sck_d = 1'b0;
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TAIL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          state_d = S_QUIET;
          // Last conversion of an averaging window publishes the mean and restarts.
          if (avg_q == AVG_LAST) begin
            upd_d = 1'b1;
            avg_d = '0;
            acc_d = '0;
            for (int k = 0; k < N_CH; k++) begin
              data_d[k*DATA_W +: DATA_W] = DATA_W'(sum_c[k*AW +: AW] >> AVG_LOG2);
            end
          end else begin
            avg_d = avg_q + NW'(1);
            acc_d = sum_c;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      upd_q   <= 1'b0;
      mode_q  <= 1'b0;
      timer_q <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      avg_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      upd_q   <= upd_d;
      mode_q  <= mode_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      data_q  <= data_d;
    end
  end

  assign spi_cs_no     = cs_q;
  assign spi_sck_o     = sck_q;
  assign busy_o        = busy_q;
  assign overrun_o     = ovr_q;
  assign data_update_o = upd_q;
  assign data_o        = data_q;

endmodule

// File: tb/tb_spi_adc_multi.sv
// Directed scoreboard bench for spi_adc_multi: one plain instance and one averaging instance.
module tb_spi_adc_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic en_a = 1'b0, mode_a = 1'b1, trig_a = 1'b0;
  logic cs_a, sck_a, busy_a, ovr_a, upd_a;
  logic [1:0] miso_a = 2'b00;
  logic [23:0] data_a;

  logic en_b = 1'b0, mode_b = 1'b1, trig_b = 1'b0;
  logic cs_b, sck_b, busy_b, ovr_b, upd_b;
  logic [1:0] miso_b = 2'b00;
  logic [23:0] data_b;

  spi_adc_multi #(.N_CH(2), .DATA_W(12), .CLK_DIV(2), .SAMPLE_DIV(100),
                  .QUIET_CYC(4), .AVG_LOG2(0)) dut_a (
    .clk(clk), .rst(rst), .en_i(en_a), .mode_i(mode_a), .trigger_i(trig_a),
    .spi_cs_no(cs_a), .spi_sck_o(sck_a), .spi_miso_i(miso_a), .busy_o(busy_a),
    .overrun_o(ovr_a), .data_update_o(upd_a), .data_o(data_a));

  spi_adc_multi #(.N_CH(2), .DATA_W(12), .CLK_DIV(2), .SAMPLE_DIV(100),
                  .QUIET_CYC(4), .AVG_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .en_i(en_b), .mode_i(mode_b), .trigger_i(trig_b),
    .spi_cs_no(cs_b), .spi_sck_o(sck_b), .spi_miso_i(miso_b), .busy_o(busy_b),
    .overrun_o(ovr_b), .data_update_o(upd_b), .data_o(data_b));

  // ADC models: bit 15-k is presented on the k-th SCK falling edge of the frame.
  logic [15:0] fa [2];
  logic [15:0] fb [2];
  int bit_a = 0, bit_b = 0;

  always @(negedge sck_a or negedge cs_a) begin
    if (!cs_a) begin
      if (sck_a) bit_a = 0;
      else if (bit_a < 16) begin
        miso_a[0] = fa[0][15-bit_a];
        miso_a[1] = fa[1][15-bit_a];
        bit_a++;
      end
    end
  end

  always @(negedge sck_b or negedge cs_b) begin
    if (!cs_b) begin
      if (sck_b) bit_b = 0;
      else if (bit_b < 16) begin
        miso_b[0] = fb[0][15-bit_b];
        miso_b[1] = fb[1][15-bit_b];
        bit_b++;
      end
    end
  end

  int ncyc = 0;
  logic prev_cs_a = 1'b1, prev_sck_a = 1'b1, prev_busy_a = 1'b0;
  int cs_len_a = 0, last_cs_len_a = 0, busy_len_a = 0, last_busy_len_a = 0;
  int rises_a = 0, falls_a = 0, ovr_cnt_a = 0, upd_cnt_a = 0;
  int upd_cnt_b = 0, ovr_cnt_b = 0;
  logic [23:0] obs_a [$];
  logic [23:0] obs_b [$];
  logic [23:0] exp_a [$];
  logic [23:0] exp_b [$];
  int fall_q [$];

  always @(negedge clk) begin
    ncyc++;
    if (prev_cs_a && !cs_a) begin
      falls_a++;
      fall_q.push_back(ncyc);
      rises_a  = 0;
      cs_len_a = 0;
    end
    if (!cs_a) cs_len_a++;
    if (!prev_cs_a && cs_a) last_cs_len_a = cs_len_a;
    if (!prev_busy_a && busy_a) busy_len_a = 0;
    if (busy_a) busy_len_a++;
    if (prev_busy_a && !busy_a) last_busy_len_a = busy_len_a;
    if (!prev_sck_a && sck_a && !cs_a) rises_a++;
    if (ovr_a) ovr_cnt_a++;
    if (upd_a) begin
      upd_cnt_a++;
      obs_a.push_back(data_a);
    end
    if (ovr_b) ovr_cnt_b++;
    if (upd_b) begin
      upd_cnt_b++;
      obs_b.push_back(data_b);
    end
    prev_cs_a   = cs_a;
    prev_sck_a  = sck_a;
    prev_busy_a = busy_a;
  end

  int vec = 0, errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_a(input string tag);
    if (obs_a.size() == 0 || exp_a.size() == 0) chk({tag, "_missing"}, 64'd0, 64'd1);
    else chk(tag, 64'(obs_a.pop_front()), 64'(exp_a.pop_front()));
  endtask

  task automatic pop_b(input string tag);
    if (obs_b.size() == 0 || exp_b.size() == 0) chk({tag, "_missing"}, 64'd0, 64'd1);
    else chk(tag, 64'(obs_b.pop_front()), 64'(exp_b.pop_front()));
  endtask

  task automatic wait_upd_a(input int target, input int budget, input string tag);
    int n = 0;
    while (upd_cnt_a < target && n < budget) begin tick(1); n++; end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_fall_a(input int target, input int budget, input string tag);
    int n = 0;
    while (falls_a < target && n < budget) begin tick(1); n++; end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_rise_a(input int target, input int budget, input string tag);
    int n = 0;
    while (rises_a < target && n < budget) begin tick(1); n++; end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic frame_b(input logic [15:0] ch0, input logic [15:0] ch1, input string tag);
    int n = 0;
    fb[0] = ch0;
    fb[1] = ch1;
    trig_b = 1'b1;
    tick(1);
    trig_b = 1'b0;
    while (busy_b && n < 200) begin tick(1); n++; end
    chk(tag, 64'(n < 200), 64'd1);
    tick(2);
  endtask

  initial begin
    int f0, u0, o0, bad, prev;
    logic [15:0] vals [4];
    fa[0] = 16'h0; fa[1] = 16'h0; fb[0] = 16'h0; fb[1] = 16'h0;

    tick(3);
    chk("rst_cs", 64'(cs_a), 64'd1);
    chk("rst_sck", 64'(sck_a), 64'd1);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_ovr", 64'(ovr_a), 64'd0);
    chk("rst_upd", 64'(upd_a), 64'd0);
    chk("rst_data", 64'(data_a), 64'd0);
    rst = 1'b0;
    tick(2);

    // Basic triggered capture
    fa[0] = 16'h0ABC; fa[1] = 16'h0123;
    exp_a.push_back(24'h123ABC);
    en_a = 1'b1; mode_a = 1'b1;
    trig_a = 1'b1;
    tick(1);
    trig_a = 1'b0;
    chk("start_cs", 64'(cs_a), 64'd0);
    chk("start_busy", 64'(busy_a), 64'd1);
    wait_upd_a(1, 200, "basic_timeout");
    tick(10);
    pop_a("basic_data");
    chk("basic_cs_len", 64'(last_cs_len_a), 64'd68);
    chk("basic_sck_rises", 64'(rises_a), 64'd16);
    chk("basic_busy_len", 64'(last_busy_len_a), 64'd72);
    chk("basic_upd_cnt", 64'(upd_cnt_a), 64'd1);

    // Overrun: second trigger while busy is dropped
    fa[0] = 16'h0555; fa[1] = 16'h0AAA;
    exp_a.push_back(24'hAAA555);
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    tick(9);
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    wait_upd_a(2, 200, "ovr_timeout");
    tick(100);
    chk("ovr_pulses", 64'(ovr_cnt_a), 64'd1);
    chk("ovr_frames", 64'(falls_a), 64'd2);
    chk("ovr_upd_cnt", 64'(upd_cnt_a), 64'd2);
    pop_a("ovr_data");

    // Continuous timer mode for 1000 cycles
    fa[0] = 16'h0F0F; fa[1] = 16'h0777;
    fall_q.delete();
    f0 = falls_a; u0 = upd_cnt_a; o0 = ovr_cnt_a;
    for (int i = 0; i < 10; i++) exp_a.push_back(24'h777F0F);
    mode_a = 1'b0;
    tick(1000);
    en_a = 1'b0;
    wait_upd_a(u0 + 10, 200, "cont_timeout");
    tick(50);
    chk("cont_frames", 64'(falls_a - f0), 64'd10);
    bad = 0;
    prev = -1;
    foreach (fall_q[i]) begin
      if (prev >= 0 && fall_q[i] - prev != 100) bad++;
      prev = fall_q[i];
    end
    chk("cont_spacing", 64'(bad), 64'd0);
    chk("cont_no_ovr", 64'(ovr_cnt_a - o0), 64'd0);
    for (int i = 0; i < 10; i++) pop_a("cont_data");

    // Disable in the middle of SHIFT
    fa[0] = 16'h0321; fa[1] = 16'h0654;
    exp_a.push_back(24'h654321);
    f0 = falls_a; u0 = upd_cnt_a;
    en_a = 1'b1;
    wait_fall_a(f0 + 1, 150, "dis_fall_timeout");
    wait_rise_a(5, 100, "dis_rise_timeout");
    en_a = 1'b0;
    wait_upd_a(u0 + 1, 200, "dis_upd_timeout");
    tick(300);
    chk("dis_frames", 64'(falls_a - f0), 64'd1);
    chk("dis_upd_cnt", 64'(upd_cnt_a - u0), 64'd1);
    pop_a("dis_data");

    // Averaging over four conversions
    en_b = 1'b1; mode_b = 1'b1;
    vals[0] = 16'd100; vals[1] = 16'd101; vals[2] = 16'd102; vals[3] = 16'd104;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_b.push_back(24'hF00065);
      frame_b(vals[i], 16'hAF00, "avg_timeout");
      if (i < 3) chk("avg_no_early_upd", 64'(upd_cnt_b), 64'd0);
    end
    chk("avg_upd_cnt", 64'(upd_cnt_b), 64'd1);
    pop_b("avg_data");
    exp_b.push_back(24'hFFFFFF);
    for (int i = 0; i < 4; i++) frame_b(16'hFFFF, 16'hFFFF, "fs_timeout");
    chk("fs_upd_cnt", 64'(upd_cnt_b), 64'd2);
    pop_b("fs_data");
    chk("avg_no_ovr", 64'(ovr_cnt_b), 64'd0);

    // Asynchronous reset in the middle of a frame
    mode_a = 1'b1; en_a = 1'b1;
    trig_a = 1'b1; tick(1); trig_a = 1'b0;
    tick(1);
    wait_rise_a(3, 100, "rstmid_timeout");
    rst = 1'b1;
    #1;
    chk("rstmid_cs", 64'(cs_a), 64'd1);
    chk("rstmid_sck", 64'(sck_a), 64'd1);
    chk("rstmid_busy", 64'(busy_a), 64'd0);
    chk("rstmid_data_a", 64'(data_a), 64'd0);
    chk("rstmid_data_b", 64'(data_b), 64'd0);
    tick(3);
    rst = 1'b0;
    f0 = falls_a; u0 = upd_cnt_a;
    tick(200);
    chk("rstmid_no_upd", 64'(upd_cnt_a - u0), 64'd0);
    chk("rstmid_no_frame", 64'(falls_a - f0), 64'd0);
    chk("sb_a_empty", 64'(exp_a.size() + obs_a.size()), 64'd0);
    chk("sb_b_empty", 64'(exp_b.size() + obs_b.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
